div_unit: RTL



---
 rtl/div_unit_pkg.sv | 32 +++
 rtl/div_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types, constants and helpers for the multi-cycle divider.
//   div_state_e  : divider FSM state codes (2-bit)
//   DivStart/DivStop, DivResultReady/DivResultNotReady, RstEnable, ZeroWord,
//   DoubleRegBus : handshake levels, reset level and bus widths
//   neg32/mag32  : two's complement negate and signed-mode magnitude
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam int unsigned DoubleRegBus      = 64;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of x; only negative values in signed mode are flipped.
    function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] x);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit signed/unsigned restoring divider, one quotient
// bit per cycle, responder on the EX-stage divide handshake.
// Optional feature: define DIV_EARLY_OUT_EN to bypass iteration when
// |dividend| < |divisor|.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   signed_div_i : 1 = DIV (signed), 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by EX until ready_o
//   annul_i      : flush, abandons any operation
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result valid, registered
module div_unit
    import div_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [31:0]             opdata1_i,
    input  logic [31:0]             opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [63:0] work_q;      // {remainder, quotient} working register
    logic [31:0] divisor_q;   // divisor magnitude
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic [31:0] mag1, mag2;
    logic [64:0] shifted;
    logic        borrow;
    logic [31:0] diff;
    logic [63:0] step_d;
    logic [31:0] quo_fix, rem_fix;

    assign mag1 = mag32(signed_div_i, opdata1_i);
    assign mag2 = mag32(signed_div_i, opdata2_i);

    always_comb begin
        shifted = {work_q, 1'b0};
        // 33-bit partial remainder vs divisor; when it fits, the true
        // difference is below 2^32 so the low 32 bits carry it exactly.
        borrow  = shifted[64:32] < {1'b0, divisor_q};
        diff    = shifted[63:32] - divisor_q;
        step_d  = shifted[63:0];
        if (!borrow) begin
            step_d = {diff, shifted[31:1], 1'b1};
        end
        quo_fix = neg_quo_q ? neg32(step_d[31:0])  : step_d[31:0];
        rem_fix = neg_rem_q ? neg32(step_d[63:32]) : step_d[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_o   <= DivResultNotReady;
            result_o  <= '0;
        end else if (annul_i) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
        end else begin
            case (state_q)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart) begin
                        cnt_q     <= '0;
                        divisor_q <= mag2;
                        neg_quo_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_q <= signed_div_i & opdata1_i[31];
                        if (opdata2_i == ZeroWord) begin
                            work_q  <= '0;
                            state_q <= DivByZero;
`ifdef DIV_EARLY_OUT_EN
                        end else if (mag1 < mag2) begin
                            // Early-out rides the one-cycle DivByZero hop so
                            // its ready_o timing matches the zero-divisor path.
                            work_q  <= {opdata1_i, ZeroWord};
                            state_q <= DivByZero;
`endif
                        end else begin
                            work_q  <= {ZeroWord, mag1};
                            state_q <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    state_q <= DivEnd;
                end
                DivOn: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        work_q  <= {rem_fix, quo_fix};
                        state_q <= DivEnd;
                    end else begin
                        work_q <= step_d;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_q  <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DivResultReady;
                        result_o <= work_q;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

endmodule
